// File: rtl/rat_pkg.sv
// rat_pkg: shared types and constants for the rename-stage alias table and its checkpoints.
package rat_pkg;
    localparam int ZERO_REG = 0;
    localparam int DEF_AW = 5;
    localparam int DEF_PW = 6;
    localparam int DEF_CW = 2;
    typedef enum logic {SEL_RAT, SEL_BYP} dest_reg_sel_e;
    typedef logic [DEF_PW-1:0] prn_t;
    typedef logic [DEF_AW-1:0] arn_t;
    typedef logic [DEF_CW-1:0] ckpt_id_t;
endpackage

// File: rtl/rat_ckpt_queue.sv
// rat_ckpt_queue: branch checkpoint ring with valid/released bits, head/tail pointers,
// full flag and the mispredict squash mask (CKPT_DEPTH must be a power of two).
module rat_ckpt_queue
    import rat_pkg::*;
#(
    parameter int CKPT_DEPTH = 4,
    parameter int CW = $clog2(CKPT_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc,
    input  logic                  res_valid,
    input  logic                  res_mispred,
    input  logic [CW-1:0]         res_id,
    input  logic                  recov,
    output logic [CW-1:0]         tail,
    output logic [CKPT_DEPTH-1:0] vld,
    output logic                  ckpt_full
);
    logic [CKPT_DEPTH-1:0] vld_q, rel_q, squash;
    logic [CW-1:0] head_q, tail_q, span;
    logic res_ok;

    assign res_ok = res_valid & vld_q[res_id];
    assign span = tail_q - res_id;
    assign tail = tail_q;
    assign vld = vld_q;
    assign ckpt_full = &vld_q;

    // span==0 with a valid id only happens when the ring is full: squash everything
    always_comb begin
        squash = '0;
        for (int k = 0; k < CKPT_DEPTH; k++)
            squash[k] = (span == '0) || ((CW'(k) - res_id) < span);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || recov) begin
            vld_q <= '0;
            rel_q <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else if (res_ok && res_mispred) begin
            vld_q <= vld_q & ~squash;
            rel_q <= rel_q & ~squash;
            tail_q <= res_id;
        end else begin
            if (alloc) begin
                vld_q[tail_q] <= 1'b1;
                tail_q <= tail_q + 1'b1;
            end
            if (res_ok)
                rel_q[res_id] <= 1'b1;
            if (vld_q[head_q] && rel_q[head_q]) begin
                vld_q[head_q] <= 1'b0;
                rel_q[head_q] <= 1'b0;
                head_q <= head_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/rat_ckpt.sv
// rat_ckpt: register alias table with intra-group bypass and branch checkpoints.
// Optional RAT_SVA_EN adds concurrent assertions.
module rat_ckpt
    import rat_pkg::*;
#(
    parameter int MACHINE_WIDTH = 3,
    parameter int ARF_DEPTH = 32,
    parameter int PRF_DEPTH = 64,
    parameter int CKPT_DEPTH = 4,
    parameter int AW = $clog2(ARF_DEPTH),
    parameter int PW = $clog2(PRF_DEPTH),
    parameter int CW = $clog2(CKPT_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MACHINE_WIDTH-1:0]    lane_valid,
    input  logic [MACHINE_WIDTH*AW-1:0] ar_src1,
    input  logic [MACHINE_WIDTH*AW-1:0] ar_src2,
    input  logic [MACHINE_WIDTH*AW-1:0] ar_dest,
    input  logic [MACHINE_WIDTH-1:0]    src1_use,
    input  logic [MACHINE_WIDTH-1:0]    src2_use,
    input  logic [MACHINE_WIDTH-1:0]    dest_use,
    input  logic [MACHINE_WIDTH-1:0]    lane_is_br,
    input  logic [MACHINE_WIDTH*PW-1:0] free_prn,
    input  logic [MACHINE_WIDTH-1:0]    free_prn_valid,
    output logic [MACHINE_WIDTH-1:0]    free_prn_ready,
    output logic [MACHINE_WIDTH*PW-1:0] pr_src1,
    output logic [MACHINE_WIDTH*PW-1:0] pr_src2,
    output logic [MACHINE_WIDTH*PW-1:0] pr_dest,
    output logic [MACHINE_WIDTH*PW-1:0] pr_dest_prev,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CW-1:0]               br_ckpt_id,
    input  logic                        br_res_valid,
    input  logic [CW-1:0]               br_res_id,
    input  logic                        br_res_mispred,
    input  logic                        recov_arch_st,
    input  logic [ARF_DEPTH*PW-1:0]     arch_rat,
    output logic                        ckpt_full
);
    localparam int MW = MACHINE_WIDTH;

    logic [PW-1:0] rat_q [ARF_DEPTH];
    logic [PW-1:0] rat_n [ARF_DEPTH];
    logic [PW-1:0] snap_n [ARF_DEPTH];
    logic [PW-1:0] snap_q [CKPT_DEPTH][ARF_DEPTH];
    logic [AW-1:0] s1_a [MW], s2_a [MW], d_a [MW];
    logic [PW-1:0] fp_a [MW], ps1 [MW], ps2 [MW], pdp [MW];
    logic [MW-1:0] nd;
    logic [CKPT_DEPTH-1:0] ckpt_vld;
    logic [CW-1:0] tail;
    logic mispred, flush, has_br, accept, alloc;

    // youngest older lane writing the same register wins, otherwise the table; x0 is constant zero
    function automatic logic [PW-1:0] lookup(input logic [AW-1:0] a, input int i);
        logic [PW-1:0] r;
        r = rat_q[a];
        for (int j = 0; j < MW; j++)
            if (j < i && nd[j] && d_a[j] == a)
                r = fp_a[j];
        return (a == AW'(ZERO_REG)) ? '0 : r;
    endfunction

    for (genvar g = 0; g < MW; g++) begin : g_lane
        assign s1_a[g] = ar_src1[g*AW +: AW];
        assign s2_a[g] = ar_src2[g*AW +: AW];
        assign d_a[g] = ar_dest[g*AW +: AW];
        assign fp_a[g] = free_prn[g*PW +: PW];
        assign nd[g] = lane_valid[g] & dest_use[g] & (d_a[g] != AW'(ZERO_REG));
        assign pr_src1[g*PW +: PW] = ps1[g];
        assign pr_src2[g*PW +: PW] = ps2[g];
        assign pr_dest[g*PW +: PW] = nd[g] ? fp_a[g] : '0;
        assign pr_dest_prev[g*PW +: PW] = pdp[g];
    end

    always_comb begin
        for (int i = 0; i < MW; i++) begin
            ps1[i] = (lane_valid[i] && src1_use[i]) ? lookup(s1_a[i], i) : '0;
            ps2[i] = (lane_valid[i] && src2_use[i]) ? lookup(s2_a[i], i) : '0;
            pdp[i] = (lane_valid[i] && dest_use[i]) ? lookup(d_a[i], i) : '0;
        end
    end

    assign mispred = br_res_valid & br_res_mispred;
    assign flush = recov_arch_st | mispred;
    assign has_br = |(lane_is_br & lane_valid);
    assign accept = rst_n & in_valid & out_ready & ~flush & (&(~nd | free_prn_valid)) & ~(has_br & ckpt_full);
    assign alloc = accept & has_br;
    assign in_ready = accept;
    assign out_valid = in_valid & ~flush;
    assign free_prn_ready = {MW{accept}} & nd;
    assign br_ckpt_id = tail;

    // the snapshot captures the table after the branch lane, before any younger lane
    always_comb begin
        rat_n = rat_q;
        snap_n = rat_q;
        for (int i = 0; i < MW; i++) begin
            if (nd[i])
                rat_n[d_a[i]] = fp_a[i];
            if (lane_valid[i] && lane_is_br[i])
                snap_n = rat_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rat_q <= '{default: '0};
        else if (recov_arch_st)
            for (int k = 0; k < ARF_DEPTH; k++)
                rat_q[k] <= (k == ZERO_REG) ? '0 : arch_rat[k*PW +: PW];
        else if (mispred && ckpt_vld[br_res_id])
            rat_q <= snap_q[br_res_id];
        else if (accept)
            rat_q <= rat_n;
    end

    always_ff @(posedge clk) begin
        if (alloc)
            snap_q[tail] <= snap_n;
    end

    rat_ckpt_queue #(.CKPT_DEPTH(CKPT_DEPTH), .CW(CW)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc      (alloc),
        .res_valid  (br_res_valid),
        .res_mispred(br_res_mispred),
        .res_id     (br_res_id),
        .recov      (recov_arch_st),
        .tail       (tail),
        .vld        (ckpt_vld),
        .ckpt_full  (ckpt_full)
    );

`ifdef RAT_SVA_EN
    a_x0_zero: assert property (@(posedge clk) rst_n |-> rat_q[0] == '0);
    a_one_br: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(lane_is_br & lane_valid));
    a_no_alloc_full: assert property (@(posedge clk) disable iff (!rst_n) !(alloc && ckpt_full));
    a_res_id_valid: assert property (@(posedge clk) disable iff (!rst_n) br_res_valid |-> ckpt_vld[br_res_id]);
`else
`endif
endmodule
